// File: rtl/psum_tile_stager.sv
// psum_tile_stager
//
// Stages PSUM vectors between the PSUM SRAM and the MAC array's north input.
//
// On load_start, the block streams a tile of load_len vectors from SRAM. It
// generates the addresses itself, starting at load_base. Returned vectors land
// in a first-word-fall-through FIFO of DEPTH entries. Address issue is throttled
// so that returning data can never overrun the FIFO.
//
// A separate delay line aligns the per-column MAC valids to the output-FIFO
// write enables.
//
// Optional feature (macro PSUM_ZERO_FILL_EN):
//   defined   - mac_rd on an empty FIFO is legal. It pops nothing, presents
//               zero, and underflow is tied 0.
//   undefined - mac_rd on an empty FIFO sets the sticky underflow flag.
//
// Ports:
//   clk, reset    clock; synchronous active-high reset
//   load_start    pulse: start a tile load (ignored while load_busy or len=0)
//   load_base     first SRAM address, sampled with load_start
//   load_len      vectors in tile, sampled with load_start
//   sram_rd_en    SRAM read strobe
//   sram_addr     SRAM read address (holds its last value when idle)
//   sram_rdata    SRAM read data, valid one cycle after sram_rd_en
//   mac_rd        MAC consumes the head vector
//   mac_psum      head vector (zero when empty)
//   psum_valid    FIFO non-empty
//   fifo_level    FIFO occupancy
//   load_busy     load FSM not idle
//   load_done     one-cycle pulse after the last vector is written
//   underflow     sticky: mac_rd while empty
//   mac_valid_in  per-column MAC output valid
//   ofifo_wr      mac_valid_in delayed VALID_LAT cycles
//   dbg_state     current load FSM state (IDLE=0, REQ=1, WAIT=2)
//
// Handshake: psum_valid/mac_rd follow valid/ready semantics. A vector is
// transferred in exactly the cycle where both are high, and the pop takes
// effect at that clock edge. psum_valid never depends on mac_rd in the same
// cycle. mac_rd without psum_valid transfers nothing.

module psum_tile_stager #(
  parameter int COL       = 8,
  parameter int PSUM_BW   = 16,
  parameter int DEPTH     = 16,
  parameter int ADDR_W    = 11,
  parameter int LEN_W     = 5,
  parameter int VALID_LAT = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     load_start,
  input  logic [ADDR_W-1:0]        load_base,
  input  logic [LEN_W-1:0]         load_len,
  output logic                     sram_rd_en,
  output logic [ADDR_W-1:0]        sram_addr,
  input  logic [COL*PSUM_BW-1:0]   sram_rdata,
  input  logic                     mac_rd,
  output logic [COL*PSUM_BW-1:0]   mac_psum,
  output logic                     psum_valid,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     load_busy,
  output logic                     load_done,
  output logic                     underflow,
  input  logic [COL-1:0]           mac_valid_in,
  output logic [COL-1:0]           ofifo_wr,
  output logic [1:0]               dbg_state
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int SUM_W = LVL_W + 1;
  localparam int DW    = COL * PSUM_BW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t            state, state_n;
  logic              capture;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued;
  logic              rd_valid_q;
  logic              space_ok;
  logic              last_issue;
  logic [SUM_W-1:0]  occ_sum;

  logic [DW-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]  wptr, rptr;
  logic              push, pop;

  // ------------------------------------------------------------------
  // Load FSM
  // ------------------------------------------------------------------

  // Occupancy counts one read that is still in flight. A strobe is issued
  // only when the FIFO is guaranteed to have room for its data.
  assign occ_sum    = SUM_W'(fifo_level) + SUM_W'(rd_valid_q);
  assign space_ok   = occ_sum < SUM_W'(DEPTH);
  assign last_issue = (issued + LEN_W'(1)) == len_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n    = state;
    sram_rd_en = 1'b0;
    capture    = 1'b0;
    case (state)
      S_IDLE: begin
        if (load_start && (load_len != '0)) begin
          capture = 1'b1;
          state_n = S_REQ;
        end
      end
      S_REQ: begin
        sram_rd_en = space_ok;
        if (space_ok && last_issue) state_n = S_WAIT;
      end
      S_WAIT: begin
        // The final read's data lands during this cycle.
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign load_busy = (state != S_IDLE);
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (reset) begin
      sram_addr  <= '0;
      len_q      <= '0;
      issued     <= '0;
      rd_valid_q <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      rd_valid_q <= sram_rd_en;
      load_done  <= (state == S_WAIT);
      if (capture) begin
        sram_addr <= load_base;
        len_q     <= load_len;
        issued    <= '0;
      end else if (sram_rd_en) begin
        sram_addr <= sram_addr + ADDR_W'(1);
        issued    <= issued + LEN_W'(1);
      end
    end
  end

  // ------------------------------------------------------------------
  // FWFT FIFO
  // ------------------------------------------------------------------

  assign push       = rd_valid_q;
  assign psum_valid = (fifo_level != '0);
  assign pop        = mac_rd && psum_valid;
  assign mac_psum   = psum_valid ? mem[rptr] : '0;

  // Storage is not reset; only the pointers and level define what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= sram_rdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_level <= '0;
    end else begin
      if (push) wptr <= wptr + PTR_W'(1);
      if (pop)  rptr <= rptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
    end
  end

`ifdef PSUM_ZERO_FILL_EN
  // Reading an empty FIFO is the first-pass/no-accumulate mode. It presents
  // zero, which mac_psum already does when empty.
  assign underflow = 1'b0;
`else
  always_ff @(posedge clk) begin
    if (reset)                     underflow <= 1'b0;
    else if (mac_rd && !psum_valid) underflow <= 1'b1;
  end
`endif

  // ------------------------------------------------------------------
  // MAC valid -> output FIFO write alignment
  // ------------------------------------------------------------------

  logic [COL-1:0] vdly [VALID_LAT];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < VALID_LAT; i++) vdly[i] <= '0;
    end else begin
      vdly[0] <= mac_valid_in;
      for (int i = 1; i < VALID_LAT; i++) vdly[i] <= vdly[i-1];
    end
  end

  assign ofifo_wr = vdly[VALID_LAT-1];

endmodule

// File: tb/tb_psum_tile_stager.sv
// Directed testbench for psum_tile_stager (DEPTH=16, VALID_LAT=3).
// Inputs are driven 1 time unit after the rising edge. Outputs are checked at
// the same point or on the falling edge. The SRAM model returns each address
// as its data.

module tb_psum_tile_stager;

  localparam int COL       = 8;
  localparam int PSUM_BW   = 16;
  localparam int DEPTH     = 16;
  localparam int ADDR_W    = 11;
  localparam int LEN_W     = 5;
  localparam int VALID_LAT = 3;
  localparam int DW        = COL * PSUM_BW;

  logic                clk;
  logic                reset;
  logic                load_start;
  logic [ADDR_W-1:0]   load_base;
  logic [LEN_W-1:0]    load_len;
  logic                sram_rd_en;
  logic [ADDR_W-1:0]   sram_addr;
  logic [DW-1:0]       sram_rdata;
  logic                mac_rd;
  logic [DW-1:0]       mac_psum;
  logic                psum_valid;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                load_busy;
  logic                load_done;
  logic                underflow;
  logic [COL-1:0]      mac_valid_in;
  logic [COL-1:0]      ofifo_wr;
  logic [1:0]          dbg_state;

  psum_tile_stager #(
    .COL(COL), .PSUM_BW(PSUM_BW), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .LEN_W(LEN_W), .VALID_LAT(VALID_LAT)
  ) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_base(load_base),
    .load_len(load_len), .sram_rd_en(sram_rd_en), .sram_addr(sram_addr),
    .sram_rdata(sram_rdata), .mac_rd(mac_rd), .mac_psum(mac_psum),
    .psum_valid(psum_valid), .fifo_level(fifo_level), .load_busy(load_busy),
    .load_done(load_done), .underflow(underflow), .mac_valid_in(mac_valid_in),
    .ofifo_wr(ofifo_wr), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- SRAM model: data = address ----------------
  initial sram_rdata = '0;
  always @(posedge clk) begin
    if (sram_rd_en) sram_rdata <= DW'(sram_addr);
  end

  // ---------------- scoreboard ----------------
  logic [DW-1:0] exp_q[$];
  int n_checks   = 0;
  int n_errors   = 0;
  int strobe_cnt = 0;
  int done_cnt   = 0;
  int max_level  = 0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor on the falling edge: count strobes and done pulses, track the
  // peak level, and compare each popped vector with the expected queue.
  always @(negedge clk) begin
    if (!reset) begin
      if (sram_rd_en) strobe_cnt++;
      if (load_done)  done_cnt++;
      if (int'(fifo_level) > max_level) max_level = int'(fifo_level);
      if (mac_rd && psum_valid) begin
        if (exp_q.size() == 0) check("pop_unexpected", mac_psum, '1);
        else                   check("pop_data", mac_psum, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_tile(input logic [ADDR_W-1:0] base, input int len);
    logic [ADDR_W-1:0] a;
    a = base;
    for (int i = 0; i < len; i++) begin
      exp_q.push_back(DW'(a));
      a = a + ADDR_W'(1);
    end
  endtask

  // Leaves load_start high for the current cycle; the caller ticks next.
  task automatic start_load(input logic [ADDR_W-1:0] base, input int len);
    load_start = 1'b1;
    load_base  = base;
    load_len   = LEN_W'(len);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (load_busy && n < budget) begin
      tick();
      n++;
    end
    check("idle_within_budget", DW'(load_busy), '0);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_rd_en"},   DW'(sram_rd_en), '0);
    check({tag, "_addr"},    DW'(sram_addr),  '0);
    check({tag, "_valid"},   DW'(psum_valid), '0);
    check({tag, "_psum"},    mac_psum,        '0);
    check({tag, "_level"},   DW'(fifo_level), '0);
    check({tag, "_busy"},    DW'(load_busy),  '0);
    check({tag, "_done"},    DW'(load_done),  '0);
    check({tag, "_uflow"},   DW'(underflow),  '0);
    check({tag, "_ofifo"},   DW'(ofifo_wr),   '0);
  endtask

  int s0, d0;

  initial begin
    reset        = 1'b1;
    load_start   = 1'b0;
    load_base    = '0;
    load_len     = '0;
    mac_rd       = 1'b0;
    mac_valid_in = '0;

    repeat (3) tick();
    check_reset_values("rst");
    check("rst_state", DW'(dbg_state), '0);
    reset = 1'b0;
    repeat (2) tick();

    // ---------- basic load: base 0x040, len 8 ----------
    d0 = done_cnt;
    start_load(11'h040, 8);
    expect_tile(11'h040, 8);
    for (int i = 1; i <= 11; i++) begin
      tick();
      if (i == 1) load_start = 1'b0;
      check("t1_busy",  DW'(load_busy),  DW'(i <= 9));
      check("t1_rd_en", DW'(sram_rd_en), DW'(i <= 8));
      if (i <= 8) check("t1_addr", DW'(sram_addr), DW'(11'h040 + i - 1));
      check("t1_done",  DW'(load_done),  DW'(i == 10));
      check("t1_valid", DW'(psum_valid), DW'(i >= 3));
    end
    check("t1_level", DW'(fifo_level), 8);
    check("t1_done_cnt", DW'(done_cnt - d0), 1);
    mac_rd = 1'b1;
    repeat (8) tick();
    mac_rd = 1'b0;
    check("t1_valid_after", DW'(psum_valid), '0);
    check("t1_drained", DW'(exp_q.size()), '0);
    check("t1_uflow", DW'(underflow), '0);

    // ---------- back-pressure: len 20, plus ignored start while busy ----------
    tick();
    s0 = strobe_cnt;
    d0 = done_cnt;
    start_load(11'h100, 20);
    expect_tile(11'h100, 20);
    tick();
    load_start = 1'b0;
    repeat (5) tick();
    start_load(11'h555, 5);
    tick();
    load_start = 1'b0;
    repeat (20) tick();
    check("bp_strobes", DW'(strobe_cnt - s0), 16);
    check("bp_level", DW'(fifo_level), 16);
    check("bp_busy", DW'(load_busy), 1);
    check("bp_rd_en", DW'(sram_rd_en), '0);
    mac_rd = 1'b1;
    repeat (20) tick();
    mac_rd = 1'b0;
    wait_idle(20);
    repeat (3) tick();
    check("bp_drained", DW'(exp_q.size()), '0);
    check("bp_strobes_total", DW'(strobe_cnt - s0), 20);
    check("bp_done_cnt", DW'(done_cnt - d0), 1);
    check("bp_level_end", DW'(fifo_level), '0);
    check("bp_uflow", DW'(underflow), '0);

    // ---------- len = 0 is ignored ----------
    s0 = strobe_cnt;
    start_load(11'h0AA, 0);
    tick();
    load_start = 1'b0;
    check("len0_busy", DW'(load_busy), '0);
    repeat (3) tick();
    check("len0_strobes", DW'(strobe_cnt - s0), '0);
    check("len0_state", DW'(dbg_state), '0);

    // ---------- underflow: mac_rd while empty ----------
    check("uf_pre", DW'(underflow), '0);
    mac_rd = 1'b1;
    tick();
    mac_rd = 1'b0;
`ifdef PSUM_ZERO_FILL_EN
    check("uf_set", DW'(underflow), '0);
`else
    check("uf_set", DW'(underflow), 1);
`endif
    check("uf_level", DW'(fifo_level), '0);
    check("uf_psum", mac_psum, '0);
    repeat (3) tick();
`ifdef PSUM_ZERO_FILL_EN
    check("uf_held", DW'(underflow), '0);
`else
    check("uf_held", DW'(underflow), 1);
`endif

    // ---------- simultaneous push/pop: len 8, then 12 (addr wrap), 12 ----------
    mac_rd = 1'b1;
    tick();
    max_level = 0;
    d0 = done_cnt;
    start_load(11'h0A0, 8);
    expect_tile(11'h0A0, 8);
    tick();
    load_start = 1'b0;
    wait_idle(40);
    repeat (4) tick();
    check("pp8_drained", DW'(exp_q.size()), '0);
    start_load(11'h7F8, 12);
    expect_tile(11'h7F8, 12);
    tick();
    load_start = 1'b0;
    wait_idle(40);
    repeat (4) tick();
    start_load(11'h200, 12);
    expect_tile(11'h200, 12);
    tick();
    load_start = 1'b0;
    wait_idle(40);
    repeat (4) tick();
    mac_rd = 1'b0;
    check("pp_drained", DW'(exp_q.size()), '0);
    check("pp_max_level", DW'(max_level), 1);
    check("pp_done_cnt", DW'(done_cnt - d0), 3);
    check("pp_level_end", DW'(fifo_level), '0);

    // ---------- reset mid-load at t+4 ----------
    tick();
    d0 = done_cnt;
    start_load(11'h300, 8);
    tick();
    load_start = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check_reset_values("rml");
    reset = 1'b0;
    repeat (6) tick();
    check("rml_no_done", DW'(done_cnt - d0), '0);
    check("rml_level", DW'(fifo_level), '0);
    check("rml_valid", DW'(psum_valid), '0);
    check("rml_busy", DW'(load_busy), '0);

    d0 = done_cnt;
    start_load(11'h020, 3);
    expect_tile(11'h020, 3);
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 1) load_start = 1'b0;
      check("r3_busy", DW'(load_busy), DW'(i <= 4));
      check("r3_done", DW'(load_done), DW'(i == 5));
      if (i <= 3) check("r3_addr", DW'(sram_addr), DW'(11'h020 + i - 1));
    end
    check("r3_level", DW'(fifo_level), 3);
    mac_rd = 1'b1;
    repeat (3) tick();
    mac_rd = 1'b0;
    check("r3_valid_after", DW'(psum_valid), '0);
    check("r3_drained", DW'(exp_q.size()), '0);
    check("r3_done_cnt", DW'(done_cnt - d0), 1);

    // ---------- valid alignment: VALID_LAT = 3 ----------
    tick();
    mac_valid_in = 8'hA5;
    for (int i = 0; i <= 5; i++) begin
      check("ofifo_wr", DW'(ofifo_wr), (i == 3) ? DW'(8'hA5) : '0);
      tick();
      mac_valid_in = '0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
